// File: rtl/mure_pkg.sv
// Shared types and widths for the multi-retire trace serializer.
// Entry record layout plus the privilege encodings used by the cause/tval mux.
package mure_pkg;

  localparam int XLEN      = 32;
  localparam int CAUSE_LEN = 32;
  localparam int PRIV_LEN  = 2;
  localparam int INST_LEN  = 32;

  localparam logic [PRIV_LEN-1:0] PRIV_U = 2'b00;
  localparam logic [PRIV_LEN-1:0] PRIV_S = 2'b01;
  localparam logic [PRIV_LEN-1:0] PRIV_H = 2'b10;
  localparam logic [PRIV_LEN-1:0] PRIV_M = 2'b11;

  typedef struct packed {
    logic [INST_LEN-1:0]  inst;
    logic [XLEN-1:0]      pc;
    logic                 iretired;
    logic                 exception;
    logic                 interrupt;
    logic                 eret;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } mure_entry_s;

  // Cause/tval only travel with a trap; everything else carries zeros there.
  function automatic mure_entry_s make_entry(
    input logic [INST_LEN-1:0]  inst,
    input logic [XLEN-1:0]      pc,
    input logic                 iretired,
    input logic                 trap,
    input logic                 eret,
    input logic [CAUSE_LEN-1:0] cause,
    input logic [XLEN-1:0]      tval,
    input logic [PRIV_LEN-1:0]  priv
  );
    mure_entry_s e;
    e.inst      = inst;
    e.pc        = pc;
    e.iretired  = iretired;
    e.exception = trap;
    e.interrupt = trap & cause[CAUSE_LEN-1];
    e.eret      = eret;
    e.cause     = trap ? cause : '0;
    e.tval      = trap ? tval : '0;
    e.priv      = priv;
    return e;
  endfunction

endpackage

// File: rtl/mure_mw_fifo.sv
// Multi-write / single-read FIFO of trace entries.
// A write group of wr_cnt entries lands all-or-nothing; a same-cycle pop counts as free space.
module mure_mw_fifo
  import mure_pkg::*;
#(
  parameter int NW    = 2,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int WC_W  = $clog2(NW + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WC_W-1:0]       wr_cnt,
  input  mure_entry_s [NW-1:0]  wr_data,
  input  logic                  pop_req,
  output logic                  accept,
  output logic                  empty,
  output mure_entry_s           head,
  output logic [CNT_W-1:0]      count
);

  mure_entry_s mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             pop;
  logic             fits;

  assign empty = (count_reg == '0);
  assign pop   = pop_req & ~empty;
  assign fits  = int'(wr_cnt) <= (DEPTH - int'(count_reg) + int'(pop));
  assign accept = (wr_cnt != '0) && fits;
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (accept) begin
      count_next = count_next + CNT_W'(wr_cnt);
    end
    count_next = count_next - CNT_W'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(wr_cnt);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // Storage carries no reset: occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < NW; i++) begin
        if (i < int'(wr_cnt)) begin
          mem[wr_ptr_reg + PTR_W'(i)] <= wr_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/multi_retire_serializer.sv
// Retirement tap: compacts up to NRET retired slots plus a trap/xRET event into
// oldest-first records and serialises them one per cycle over valid/ready.
module multi_retire_serializer
  import mure_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NRET-1:0]          valids_i,
  input  logic [NRET*INST_LEN-1:0] insts_i,
  input  logic [NRET*XLEN-1:0]     pcs_i,
  input  logic                     exception_i,
  input  logic                     eret_i,
  input  logic [CAUSE_LEN-1:0]     ucause_i,
  input  logic [CAUSE_LEN-1:0]     scause_i,
  input  logic [CAUSE_LEN-1:0]     vscause_i,
  input  logic [CAUSE_LEN-1:0]     mcause_i,
  input  logic [XLEN-1:0]          utval_i,
  input  logic [XLEN-1:0]          stval_i,
  input  logic [XLEN-1:0]          vstval_i,
  input  logic [XLEN-1:0]          mtval_i,
  input  logic [PRIV_LEN-1:0]      priv_lvl_i,
  input  logic                     v_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic                     iretired_o,
  output logic                     exception_o,
  output logic                     interrupt_o,
  output logic                     eret_o,
  output logic [INST_LEN-1:0]      inst_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic                     overflow_o,
  output logic                     drop_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(NRET + 1);

  logic [CAUSE_LEN-1:0]    trap_cause;
  logic [XLEN-1:0]         trap_tval;
  logic [NRET-1:0]         is_last;
  logic [WC_W-1:0]         prefix [NRET+1];
  logic                    bare_trap;
  mure_entry_s [NRET-1:0]  slot_entry;
  mure_entry_s [NRET-1:0]  wr_data;
  mure_entry_s             trap_only;
  logic [WC_W-1:0]         wr_cnt;
  logic                    accept;
  logic                    empty;
  logic                    drop;
  logic                    drop_reg;
  logic                    overflow_reg;
  mure_entry_s             head;
  mure_entry_s             rec;
  logic [CNT_W-1:0]        count;

  always_comb begin
    trap_cause = mcause_i;
    trap_tval  = mtval_i;
    case (priv_lvl_i)
      PRIV_S: begin
        trap_cause = v_i ? vscause_i : scause_i;
        trap_tval  = v_i ? vstval_i : stval_i;
      end
      PRIV_U: begin
        trap_cause = ucause_i;
        trap_tval  = utval_i;
      end
      default: begin
        trap_cause = mcause_i;
        trap_tval  = mtval_i;
      end
    endcase
  end

  // prefix[i] = number of valid slots older than slot i, i.e. its compacted position.
  always_comb begin
    prefix[0] = '0;
    for (int i = 0; i < NRET; i++) begin
      prefix[i+1] = prefix[i] + WC_W'(valids_i[i]);
    end
  end

  assign bare_trap = exception_i && (valids_i == '0);
  assign wr_cnt    = bare_trap ? WC_W'(1) : prefix[NRET];
  assign trap_only = make_entry('0, pcs_i[XLEN-1:0], 1'b0, 1'b1, 1'b0,
                                trap_cause, trap_tval, priv_lvl_i);

  // The trap/xRET event belongs to the youngest valid slot.
  for (genvar gi = 0; gi < NRET; gi++) begin : g_slot
    assign is_last[gi]    = valids_i[gi] && ((valids_i >> (gi + 1)) == '0);
    assign slot_entry[gi] = make_entry(insts_i[gi*INST_LEN +: INST_LEN],
                                       pcs_i[gi*XLEN +: XLEN], 1'b1,
                                       is_last[gi] & exception_i,
                                       is_last[gi] & eret_i,
                                       trap_cause, trap_tval, priv_lvl_i);
  end

  for (genvar gi = 0; gi < NRET; gi++) begin : g_pos
    mure_entry_s pick;
    always_comb begin
      pick = '0;
      for (int i = gi; i < NRET; i++) begin
        if (valids_i[i] && (prefix[i] == WC_W'(gi))) begin
          pick = slot_entry[i];
        end
      end
      if (gi == 0 && bare_trap) begin
        pick = trap_only;
      end
    end
    assign wr_data[gi] = pick;
  end

  mure_mw_fifo #(
    .NW    (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .pop_req (valid_o & ready_i),
    .accept  (accept),
    .empty   (empty),
    .head    (head),
    .count   (count)
  );

  assign drop = (wr_cnt != '0) && !accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      drop_reg     <= drop;
      overflow_reg <= overflow_reg | drop;
    end
  end

  // Gate the head so an empty FIFO (including just after reset) presents zeros.
  assign rec         = empty ? '0 : head;
  assign valid_o     = ~empty;
  assign iretired_o  = rec.iretired;
  assign exception_o = rec.exception;
  assign interrupt_o = rec.interrupt;
  assign eret_o      = rec.eret;
  assign inst_o      = rec.inst;
  assign pc_o        = rec.pc;
  assign cause_o     = rec.cause;
  assign tval_o      = rec.tval;
  assign priv_o      = rec.priv;
  assign overflow_o  = overflow_reg;
  assign drop_o      = drop_reg;

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_multi_retire_serializer.sv
// Directed bench for multi_retire_serializer (NRET=2, DEPTH=8) with a queue
// scoreboard: expected records are queued as bundles are driven, checked as they pop.
module tb_multi_retire_serializer;

  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        iret;
    logic        exc;
    logic        intr;
    logic        eret;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [1:0]  priv;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valids;
  logic [63:0] insts;
  logic [63:0] pcs;
  logic        exc, eret;
  logic [31:0] ucause, scause, vscause, mcause;
  logic [31:0] utval, stval, vstval, mtval;
  logic [1:0]  priv;
  logic        v;
  logic        ready;

  logic        valid_o, iretired_o, exception_o, interrupt_o, eret_o;
  logic [31:0] inst_o, pc_o, cause_o, tval_o;
  logic [1:0]  priv_o;
  logic        overflow_o, drop_o;

  int   n_vec = 0;
  int   n_err = 0;
  rec_t exp_q[$];
  bit   exp_ovf = 0;

  always #5 clk = ~clk;

  multi_retire_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valids_i(valids), .insts_i(insts), .pcs_i(pcs),
    .exception_i(exc), .eret_i(eret),
    .ucause_i(ucause), .scause_i(scause), .vscause_i(vscause), .mcause_i(mcause),
    .utval_i(utval), .stval_i(stval), .vstval_i(vstval), .mtval_i(mtval),
    .priv_lvl_i(priv), .v_i(v), .ready_i(ready),
    .valid_o(valid_o), .iretired_o(iretired_o), .exception_o(exception_o),
    .interrupt_o(interrupt_o), .eret_o(eret_o), .inst_o(inst_o), .pc_o(pc_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
    .overflow_o(overflow_o), .drop_o(drop_o)
  );

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t observed();
    rec_t r;
    r.inst = inst_o;  r.pc = pc_o;  r.iret = iretired_o; r.exc = exception_o;
    r.intr = interrupt_o; r.eret = eret_o; r.cause = cause_o; r.tval = tval_o;
    r.priv = priv_o;
    return r;
  endfunction

  task automatic drive(input logic [1:0] vl, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic ex, input logic er);
    valids = vl;
    pcs    = {pc1, pc0};
    insts  = {pc1[15:0], 16'h0013, pc0[15:0], 16'h0033};
    exc    = ex;
    eret   = er;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Reference behaviour for one sampled bundle; returns whether it must be dropped.
  task automatic model_admit(output bit dropped);
    rec_t        b[$];
    rec_t        r;
    int          last;
    int          free;
    logic [31:0] c;
    logic [31:0] t;
    last = -1;
    for (int i = 0; i < NRET; i++) if (valids[i]) last = i;
    if (priv == 2'b00) begin c = ucause; t = utval; end
    else if (priv == 2'b01) begin c = v ? vscause : scause; t = v ? vstval : stval; end
    else begin c = mcause; t = mtval; end
    for (int i = 0; i < NRET; i++) begin
      if (valids[i]) begin
        r = '0;
        r.inst = insts[i*32 +: 32];
        r.pc   = pcs[i*32 +: 32];
        r.iret = 1'b1;
        r.priv = priv;
        if (i == last && exc) begin
          r.exc = 1'b1; r.cause = c; r.tval = t; r.intr = c[31];
        end
        if (i == last && eret) r.eret = 1'b1;
        b.push_back(r);
      end
    end
    if (last < 0 && exc) begin
      r = '0;
      r.pc = pcs[31:0]; r.exc = 1'b1; r.cause = c; r.tval = t; r.intr = c[31]; r.priv = priv;
      b.push_back(r);
    end
    free = DEPTH - exp_q.size();
    dropped = 0;
    if (b.size() > 0) begin
      if (b.size() <= free) begin
        foreach (b[k]) exp_q.push_back(b[k]);
      end else begin
        dropped = 1;
      end
    end
  endtask

  // Called at a negedge with inputs already driven: check head, advance one clock.
  task automatic cycle();
    bit dropped;
    rec_t e;
    chk("valid_o", valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("record", observed(), e);
      if (ready) void'(exp_q.pop_front());
    end
    model_admit(dropped);
    exp_ovf = exp_ovf | dropped;
    @(posedge clk);
    @(negedge clk);
    chk("drop_o", drop_o, dropped);
    chk("overflow_o", overflow_o, exp_ovf);
    $display("cycle: valids=%b exc=%b eret=%b ready=%b pc0=%h pc1=%h drop=%b queued=%0d",
             valids, exc, eret, ready, pcs[31:0], pcs[63:32], dropped, exp_q.size());
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; v = 1'b0; priv = 2'b11;
    ucause = 32'h8; scause = 32'h0; vscause = 32'h0; mcause = 32'h0;
    utval = 32'h11; stval = 32'h0; vstval = 32'h0; mtval = 32'h0;
    idle();
    repeat (2) @(negedge clk);
    chk("reset_valid", valid_o, 1'b0);
    chk("reset_overflow", overflow_o, 1'b0);
    chk("reset_drop", drop_o, 1'b0);
    chk("reset_record", observed(), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-wide bundle, full throughput.
    drive(2'b11, 32'h100, 32'h104, 1'b0, 1'b0); cycle();
    idle_cycles(3);

    // Slot 1 only: compaction to position 0.
    drive(2'b10, 32'h200, 32'h204, 1'b0, 1'b0); cycle();
    idle_cycles(2);

    // S-mode interrupt attached to the youngest slot.
    priv = 2'b01; v = 1'b0; scause = 32'h8000_0005; stval = 32'hDEAD;
    drive(2'b11, 32'h300, 32'h304, 1'b1, 1'b0); cycle();
    idle_cycles(3);

    // Trap with no retired slot, M-mode.
    priv = 2'b11; mcause = 32'h2; mtval = 32'h44;
    drive(2'b00, 32'h400, 32'h0, 1'b1, 1'b0); cycle();
    idle_cycles(2);

    // xRET on a single slot; xRET with no slot is ignored.
    priv = 2'b00;
    drive(2'b01, 32'h500, 32'h0, 1'b0, 1'b1); cycle();
    drive(2'b00, 32'h510, 32'h0, 1'b0, 1'b1); cycle();
    idle_cycles(2);

    // VS-mode and U-mode cause selection.
    priv = 2'b01; v = 1'b1; vscause = 32'hC; vstval = 32'h77;
    drive(2'b01, 32'h520, 32'h0, 1'b1, 1'b0); cycle();
    priv = 2'b00; v = 1'b0;
    drive(2'b11, 32'h530, 32'h534, 1'b1, 1'b0); cycle();
    idle_cycles(3);

    // Fill to DEPTH with the consumer stalled; fifth bundle drops.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 32'h600 + 32'(i*8), 32'h604 + 32'(i*8), 1'b0, 1'b0); cycle();
    end
    idle_cycles(2);
    ready = 1'b1;
    idle_cycles(10);

    // Occupancy 7, then a two-wide push alongside a pop.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h800 + 32'(i*8), 32'h804 + 32'(i*8), 1'b0, 1'b0); cycle();
    end
    drive(2'b01, 32'h830, 32'h0, 1'b0, 1'b0); cycle();
    ready = 1'b1;
    drive(2'b11, 32'h840, 32'h844, 1'b0, 1'b0); cycle();
    drive(2'b11, 32'h850, 32'h854, 1'b0, 1'b0); cycle();
    drive(2'b01, 32'h860, 32'h0, 1'b0, 1'b0); cycle();
    idle_cycles(2);

    // Asynchronous reset in the middle of draining.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", valid_o, 1'b0);
    chk("midreset_overflow", overflow_o, 1'b0);
    chk("midreset_drop", drop_o, 1'b0);
    exp_q.delete();
    exp_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_cycles(3);

    // Traffic resumes cleanly after reset.
    drive(2'b11, 32'h700, 32'h704, 1'b0, 1'b0); cycle();
    idle_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_retire_serializer.md
# multi_retire_serializer

Parametrised successor to the CVA6 retirement tap. Accepts up to NRET retired instructions per cycle plus one trap/return event per cycle. Selects the privilege-correct cause/tval for the trap, compacts valid slots into oldest-first order, and buffers entries in a multi-write/single-read FIFO. Emits one instruction record per cycle to the trace encoder over a valid/ready handshake, and flags any bundle it had to drop.

## Interface
- NRET, 2, retirement slots per cycle (1..4)
- DEPTH, 8, FIFO entries (power of two, ≥ 2·NRET)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- valids_i  in  NRET  per-slot retire valid, slot 0 oldest
- insts_i  in  NRET·INST_LEN  per-slot opcode
- pcs_i  in  NRET·XLEN  per-slot PC
- exception_i  in  1  trap taken this cycle
- eret_i  in  1  xRET retired this cycle
- ucause_i / scause_i / vscause_i / mcause_i  in  CAUSE_LEN each  cause CSRs
- utval_i / stval_i / vstval_i / mtval_i  in  XLEN each  tval CSRs
- priv_lvl_i  in  PRIV_LEN  privilege at retirement
- v_i  in  1  virtualisation mode
- ready_i  in  1  encoder accepts record
- valid_o  out  1  record valid
- iretired_o  out  1  record is a retired instruction
- exception_o / interrupt_o / eret_o  out  1 each  event flags
- inst_o  out  INST_LEN  opcode
- pc_o  out  XLEN  instruction address
- cause_o  out  CAUSE_LEN  selected cause
- tval_o  out  XLEN  selected tval
- priv_o  out  PRIV_LEN  privilege
- overflow_o  out  1  sticky: a bundle was dropped
- drop_o  out  1  one-cycle pulse per dropped bundle

## Operation
- Bundle count n = popcount(valids_i), plus 1 if exception_i and n=0. Entries are written in ascending slot order, gaps removed.
- exception_i/eret_i attach to the highest-index valid slot. Its iretired=1 and its pc is the trapping PC.
- exception_i with n=0: a single entry with iretired=0, exception=1, pc=pcs_i[0], inst=0.
- eret_i with no valid slot: ignored.
- Cause/tval selection by priv_lvl_i:
  - 11 or 10 → m*
  - 01 with v_i=0 → s*
  - 01 with v_i=1 → vs*
  - 00 → u*
- interrupt = exception & cause[CAUSE_LEN-1].
- Non-trap entries carry cause=0, tval=0.
- Admission is all-or-nothing: the bundle is written only if free ≥ n, where free counts the slot released by a same-cycle pop.
  - Otherwise the whole bundle is discarded, drop_o=1 and overflow_o is set until reset.
- Pop occurs when valid_o & ready_i. Push and pop in the same cycle are supported.
- Occupancy is $clog2(DEPTH+1) bits. Pointers wrap modulo DEPTH.

## Timing
- Reset: all outputs 0, FIFO empty, overflow_o=0.
- Latency: a bundle sampled at edge k appears at the output (slot-0 entry) after edge k (valid_o during cycle k+1) when the FIFO was empty.
- The output is driven from the FIFO head register, with no combinational path from inputs.
- Throughput: one record per cycle while ready_i=1.
- Outputs are held stable while valid_o & !ready_i.
- Full (occupancy=DEPTH):
  - any n>0 bundle drops unless a pop frees ≥ n.
  - n=0 cycles are never drops.
- Reset asserted mid-stream: FIFO is flushed immediately and asynchronously. No partial record is emitted after release.

## Structure
- mure_pkg adds:
  - mure_entry_s {inst, pc, iretired, exception, interrupt, eret, cause, tval, priv}
  - priv-level localparams
  - existing XLEN / CAUSE_LEN / PRIV_LEN / INST_LEN
- Sub-module mure_mw_fifo: generic NW-write/1-read FIFO of mure_entry_s with wr_cnt, full-space check, pop.
- The top level keeps:
  - cause/tval mux
  - slot compaction (prefix-sum of valids)
  - drop logic

## Test plan
- NRET=2, valids=11, pcs 0x100/0x104, ready=1 → records 0x100 then 0x104 on consecutive cycles, first with valid_o in the cycle after sampling.
- valids=10 (slot 1 only), pc 0x204 → single record pc=0x204 (compaction).
- valids=11, exception_i=1, priv=01, v_i=0, scause=0x8000_0005, stval=0xDEAD, pcs 0x300/0x304 → record 0x300 plain; record 0x304 with exception=1, interrupt=1, cause=0x8000_0005, tval=0xDEAD.
- valids=00, exception_i=1, priv=11, mcause=2, pcs[0]=0x400 → one record, iretired=0, exception=1, cause=2, pc=0x400.
- ready_i=0, DEPTH=8, push 4×(valids=11) → first four accepted; fifth: drop_o pulses once, overflow_o stays 1. After ready_i=1 exactly 8 records drain in order.
- Occupancy 7, pop same cycle, valids=11 → accepted, no drop. rst_ni low mid-drain → valid_o=0 immediately, overflow_o=0.
